// File: rtl/jk_bank_ctrl_if.sv
// Command and JK-bank bus between a host and jk_bank_ctrl.
// The host side also owns the JK bank, so q is driven from the master side.
interface jk_bank_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_len, abort, q,
    input  cmd_ready, j, k, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_len, abort, q,
    output cmd_ready, j, k, busy, done, aborted
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: computes per-bit j/k from the
// latched command and q feedback to clear, set, load, toggle, count or rotate.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  jk_bank_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_ROTL   = 3'd7
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             accept_c;
  logic             multi_op_c;
  logic [WIDTH-1:0] up_tgl_c;
  logic [WIDTH-1:0] dn_tgl_c;
  logic [WIDTH-1:0] rot_c;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic             up_carry;
  logic             dn_borrow;

  assign accept_c   = bus.cmd_valid && (state_q == IDLE);
  assign multi_op_c = (bus.cmd_op >= 3'(OP_CNT_UP));

  // Next-state, command latch and completion flags
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d  = op_e'(bus.cmd_op);
          arg_d = bus.cmd_arg;
          rem_d = multi_op_c ? bus.cmd_len : CNT_W'(1);
          // NOP and zero-length multi-cycle ops complete without touching the bank
          if ((bus.cmd_op == 3'(OP_NOP)) || (multi_op_c && (bus.cmd_len == '0))) begin
            done_d = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        if (bus.abort) begin
          state_d   = IDLE;
          rem_d     = '0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-bit toggle enables for the counters: a bit flips when all lower bits carry/borrow
  always_comb begin
    up_tgl_c  = '0;
    dn_tgl_c  = '0;
    up_carry  = 1'b1;
    dn_borrow = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_tgl_c[i] = up_carry;
      dn_tgl_c[i] = dn_borrow;
      up_carry    = up_carry & bus.q[i];
      dn_borrow   = dn_borrow & ~bus.q[i];
    end
    rot_c = (bus.q << 1) | (bus.q >> (WIDTH - 1));
  end

  // j/k drive; the bank holds (j=k=0) in IDLE and in an aborting EXEC cycle
  always_comb begin
    j_c = '0;
    k_c = '0;
    if ((state_q == EXEC) && !bus.abort) begin
      case (op_q)
        OP_CLEAR: begin
          j_c = '0;
          k_c = '1;
        end
        OP_SET: begin
          j_c = '1;
          k_c = '0;
        end
        OP_LOAD: begin
          j_c = arg_q;
          k_c = ~arg_q;
        end
        OP_TOGGLE: begin
          j_c = arg_q;
          k_c = arg_q;
        end
        OP_CNT_UP: begin
          j_c = up_tgl_c;
          k_c = up_tgl_c;
        end
        OP_CNT_DN: begin
          j_c = dn_tgl_c;
          k_c = dn_tgl_c;
        end
        OP_ROTL: begin
          j_c = rot_c;
          k_c = ~rot_c;
        end
        default: begin
          j_c = '0;
          k_c = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_NOP;
      arg_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == EXEC);
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.j         = j_c;
  assign bus.k         = k_c;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: behavioural JK bank plus an arithmetic model of the
// register value, directed scenarios followed by randomized command streams.
module tb_jk_bank_ctrl;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] q_bank;
  logic [W-1:0] qm;
  int           n_cmp;
  int           n_fail;

  jk_bank_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  jk_bank_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // JK flip-flop bank: 00 hold, 01 reset, 10 set, 11 toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_bank <= '0;
    end else begin
      for (int i = 0; i < int'(W); i++) begin
        case ({bus.j[i], bus.k[i]})
          2'b00:   q_bank[i] <= q_bank[i];
          2'b01:   q_bank[i] <= 1'b0;
          2'b10:   q_bank[i] <= 1'b1;
          default: q_bank[i] <= ~q_bank[i];
        endcase
      end
    end
  end

  assign bus.q = q_bank;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_next(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] qv);
    case (op)
      3'd1:    return '0;
      3'd2:    return '1;
      3'd3:    return a;
      3'd4:    return qv ^ a;
      3'd5:    return W'(qv + W'(1));
      3'd6:    return W'(qv - W'(1));
      3'd7:    return W'((qv << 1) | (qv >> (W - 1)));
      default: return qv;
    endcase
  endfunction

  function automatic void model_jk(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] qv,
                                   output logic [W-1:0] ej, output logic [W-1:0] ek);
    logic [W-1:0] nx;
    nx = model_next(op, a, qv);
    ej = '0;
    ek = '0;
    case (op)
      3'd1: begin ej = '0; ek = '1; end
      3'd2: begin ej = '1; ek = '0; end
      3'd3: begin ej = a;  ek = ~a; end
      3'd4: begin ej = a;  ek = a;  end
      3'd5, 3'd6: begin ej = qv ^ nx; ek = qv ^ nx; end
      3'd7: begin ej = nx; ek = ~nx; end
      default: begin ej = '0; ek = '0; end
    endcase
  endfunction

  // Issues one command in the current (IDLE) cycle and follows it to its done cycle
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] arg, input logic [CW-1:0] len,
                        input int abort_at, input string tag);
    int           n_exec;
    bit           ab;
    logic [W-1:0] ej, ek;
    n_exec = (op == 3'd0) ? 0 : (op <= 3'd4) ? 1 : int'(len);
    ab = (abort_at >= 1) && (abort_at <= n_exec);
    if (ab) n_exec = abort_at;

    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b want 1", tag, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.cmd_len   = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_arg   = W'($urandom);
    bus.cmd_len   = CW'($urandom);

    for (int c = 1; c <= n_exec; c++) begin
      if (ab && c == abort_at) begin
        bus.abort = 1'b1;
        #1;
        ej = '0;
        ek = '0;
      end else begin
        model_jk(op, arg, qm, ej, ek);
      end
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s exec_flags c%0d: got busy=%b ready=%b done=%b want 1 0 0",
                 tag, c, bus.busy, bus.cmd_ready, bus.done);
      end
      n_cmp++;
      if (bus.j !== ej || bus.k !== ek) begin
        n_fail++;
        $display("FAIL %s jk c%0d: got j=%b k=%b want j=%b k=%b", tag, c, bus.j, bus.k, ej, ek);
      end
      @(posedge clk); #1;
      bus.abort = 1'b0;
      if (!(ab && c == abort_at)) qm = model_next(op, arg, qm);
      n_cmp++;
      if (q_bank !== qm) begin
        n_fail++; $display("FAIL %s q c%0d: got %b want %b", tag, c, q_bank, qm);
      end
    end

    n_cmp++;
    if (bus.done !== 1'b1 || bus.aborted !== ab) begin
      n_fail++;
      $display("FAIL %s done: got done=%b aborted=%b want 1 %b", tag, bus.done, bus.aborted, ab);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.j !== '0 || bus.k !== '0) begin
      n_fail++;
      $display("FAIL %s done_idle: got busy=%b ready=%b j=%b k=%b want 0 1 0 0",
               tag, bus.busy, bus.cmd_ready, bus.j, bus.k);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b aborted=%b ready=%b want 0 0 0 1",
               bus.busy, bus.done, bus.aborted, bus.cmd_ready);
    end
    n_cmp++;
    if (bus.j !== '0 || bus.k !== '0 || q_bank !== '0) begin
      n_fail++; $display("FAIL reset_jkq: got j=%b k=%b q=%b want 0", bus.j, bus.k, q_bank);
    end
  endtask

  task automatic test_load();
    do_cmd(3'd3, 4'b1010, 8'd0, 0, "load");
    n_cmp++;
    if (q_bank !== 4'b1010) begin
      n_fail++; $display("FAIL load_value: got %b want 1010", q_bank);
    end
  endtask

  task automatic test_tog_set_clr();
    do_cmd(3'd4, 4'b0110, 8'd0, 0, "toggle");
    n_cmp++;
    if (q_bank !== 4'b1100) begin n_fail++; $display("FAIL toggle_value: got %b want 1100", q_bank); end
    do_cmd(3'd2, 4'b0000, 8'd0, 0, "set");
    n_cmp++;
    if (q_bank !== 4'b1111) begin n_fail++; $display("FAIL set_value: got %b want 1111", q_bank); end
    do_cmd(3'd1, 4'b1111, 8'd0, 0, "clear");
    n_cmp++;
    if (q_bank !== 4'b0000) begin n_fail++; $display("FAIL clear_value: got %b want 0000", q_bank); end
  endtask

  task automatic test_count();
    do_cmd(3'd3, 4'b1110, 8'd0, 0, "cnt_preload");
    do_cmd(3'd5, 4'b0000, 8'd3, 0, "cnt_up");
    n_cmp++;
    if (q_bank !== 4'b0001) begin n_fail++; $display("FAIL cnt_up_wrap: got %b want 0001", q_bank); end
    do_cmd(3'd6, 4'b0000, 8'd2, 0, "cnt_dn");
    n_cmp++;
    if (q_bank !== 4'b1111) begin n_fail++; $display("FAIL cnt_dn_wrap: got %b want 1111", q_bank); end
  endtask

  task automatic test_rotl();
    do_cmd(3'd3, 4'b1000, 8'd0, 0, "rotl_preload");
    do_cmd(3'd7, 4'b0000, 8'd2, 0, "rotl");
    n_cmp++;
    if (q_bank !== 4'b0010) begin n_fail++; $display("FAIL rotl_value: got %b want 0010", q_bank); end
  endtask

  task automatic test_abort();
    do_cmd(3'd1, 4'b0000, 8'd0, 0, "abort_clear");
    do_cmd(3'd5, 4'b0000, 8'd10, 4, "abort_cnt");
    n_cmp++;
    if (q_bank !== 4'b0011) begin n_fail++; $display("FAIL abort_value: got %b want 0011", q_bank); end
    // abort while idle must do nothing
    bus.abort = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.busy !== 1'b0 || q_bank !== 4'b0011) begin
        n_fail++;
        $display("FAIL abort_idle c%0d: got done=%b aborted=%b busy=%b q=%b want 0 0 0 0011",
                 c, bus.done, bus.aborted, bus.busy, q_bank);
      end
    end
    bus.abort = 1'b0;
  endtask

  task automatic test_zero_len();
    do_cmd(3'd5, 4'b0000, 8'd0, 0, "zero_len");
    n_cmp++;
    if (q_bank !== 4'b0011) begin n_fail++; $display("FAIL zero_len_q: got %b want 0011", q_bank); end
    do_cmd(3'd0, 4'b1111, 8'd5, 0, "nop");
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_after: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_arg   = '0;
    bus.cmd_len   = 8'd10;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      qm = model_next(3'd5, '0, qm);
    end
    n_cmp++;
    if (bus.busy !== 1'b1 || q_bank !== qm) begin
      n_fail++; $display("FAIL rstmid_pre: got busy=%b q=%b want 1 %b", bus.busy, q_bank, qm);
    end
    rst_n = 1'b0;
    #1;
    qm = '0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.j !== '0 || bus.k !== '0 || q_bank !== '0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_now: got busy=%b j=%b k=%b q=%b done=%b want 0 0 0 0 0",
               bus.busy, bus.j, bus.k, q_bank, bus.done);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || q_bank !== '0) begin
        n_fail++;
        $display("FAIL rstmid_after c%0d: got done=%b ready=%b q=%b want 0 1 0000",
                 c, bus.done, bus.cmd_ready, q_bank);
      end
    end
    do_cmd(3'd3, 4'b0101, 8'd0, 0, "rstmid_load");
    n_cmp++;
    if (q_bank !== 4'b0101) begin n_fail++; $display("FAIL rstmid_load_value: got %b want 0101", q_bank); end
  endtask

  task automatic test_random();
    logic [2:0]    op;
    logic [W-1:0]  arg;
    logic [CW-1:0] len;
    int            ab_at;
    for (int n = 0; n < 60; n++) begin
      op    = 3'($urandom_range(0, 7));
      arg   = W'($urandom);
      len   = CW'($urandom_range(0, 6));
      ab_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      do_cmd(op, arg, len, ab_at, "random");
      if ($urandom_range(0, 2) == 0) begin
        bus.abort = 1'($urandom);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.j !== '0 || bus.k !== '0 || q_bank !== qm) begin
          n_fail++;
          $display("FAIL random_gap: got done=%b j=%b k=%b q=%b want 0 0 0 %b",
                   bus.done, bus.j, bus.k, q_bank, qm);
        end
      end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    qm            = '0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_arg   = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    #23;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_load();
    test_tog_set_clr();
    test_count();
    test_rotl();
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for an external bank of WIDTH JK flip-flops, one instance of the team's JK flip-flop module per bit, all sharing clk and rst_n.
- Accepts operation commands over a valid/ready handshake and computes each bit's j/k every cycle from the command and the bank's q feedback.
- Supports hold, clear, set, load, masked toggle, count up/down and rotate, so lab boards get counters and registers built purely from JK cells.

Parameters:
WIDTH, 4, number of JK flip-flops in the controlled bank
CNT_W, 8, width of the cmd_len cycle-count field

Ports:
clk  input  1  rising-edge clock, shared with the JK bank
rst_n  input  1  asynchronous active-low reset, shared with the JK bank
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 ROTL
cmd_arg  input  WIDTH  LOAD value or TOGGLE mask
cmd_len  input  CNT_W  execute cycles for ops 5-7
abort  input  1  terminate the current command
q  input  WIDTH  JK bank outputs (feedback)
j  output  WIDTH  J inputs to the bank
k  output  WIDTH  K inputs to the bank
busy  output  1  command executing
done  output  1  one-cycle completion pulse
aborted  output  1  qualifies done: 1 means the command ended by abort

Behaviour:
- States: IDLE and EXEC.
- Reset (async, rst_n low): state IDLE; latched op/arg and remaining counter cleared; busy=0, done=0, aborted=0, j=0, k=0. The bank resets to q=0 at the same time.
- cmd_ready = (state==IDLE). A command is accepted when cmd_valid && cmd_ready at a rising edge.
- On acceptance, op, arg and len are latched and the state moves to EXEC.
  - remaining = 1 for ops 1-4.
  - remaining = cmd_len for ops 5-7.
- NOP, and ops 5-7 with cmd_len=0, do not enter EXEC. They stay in IDLE and pulse done the next cycle, with j=k=0 throughout.
- IDLE drives j=0, k=0 (bank holds).
- EXEC j/k are combinational from latched op/arg and q:
  - CLEAR: j=0, k=all-ones.
  - SET: j=all-ones, k=0.
  - LOAD: j=arg, k=~arg.
  - TOGGLE: j=k=arg.
  - CNT_UP: j[i]=k[i]=&q[i-1:0], with bit 0 always 1. Wraps all-ones to 0.
  - CNT_DN: j[i]=k[i]=&~q[i-1:0], with bit 0 always 1. Wraps 0 to all-ones.
  - ROTL: j[i]=q[i-1], j[0]=q[WIDTH-1], k=~j.
- busy=1 exactly while in EXEC.
- remaining decrements at each EXEC edge. At the edge where remaining==1, the state returns to IDLE and done is registered to 1 for one cycle with aborted=0.
- Latency: accepted at edge T; EXEC cycles are T+1 through T+len; the bank updates at each EXEC edge. done is high in the cycle after the last EXEC cycle, when q already holds the final value.
- A new command may be accepted in the same cycle done is high, because the state is IDLE then.
- abort sampled high during EXEC:
  - j and k are forced to 0 combinationally in that cycle, so the bank holds.
  - Next edge: state returns to IDLE, done=1 and aborted=1.
  - abort is ignored in IDLE.
- cmd_* inputs are ignored outside acceptance; the latched copies are used for the whole command.
- rst_n asserted mid-command aborts immediately with no done pulse. The first command accepted after release starts from q=0.

Test Plan:
- Reset, then LOAD arg=1010 -> one EXEC cycle with j=1010, k=0101; q=1010; done=1 and aborted=0 in the next cycle; busy high for 1 cycle.
- From q=1010: TOGGLE 0110, then SET, then CLEAR -> q sequence 1100, 1111, 0000; one done pulse per command; cmd_ready low only during each EXEC cycle.
- From q=1110: CNT_UP len=3 -> q 1111, 0000, 0001 (wrap), busy for 3 cycles. Then CNT_DN len=2 -> q 0000, 1111.
- From q=1000: ROTL len=2 -> q 0001, 0010.
- CNT_UP len=10 from 0 with abort raised in the 4th EXEC cycle -> q stops at 0011, then done=1 and aborted=1. Separately, CNT_UP with len=0 -> q unchanged, done the next cycle, busy never set.
- CNT_UP len=10 with rst_n pulled low after 3 cycles -> busy=0, j=k=0 and q=0 immediately, no done pulse. After release, cmd_ready=1 and a LOAD 0101 completes normally.
